// File: rtl/seq_branch_compare.sv
// ============================================================================
// Module   : seq_branch_compare
// Brief    : Chunk-serial RV32I branch comparator (MSB chunk first); optional
//            early exit on first differing chunk via COMPARE_EARLY_EXIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_branch_compare #(
  parameter int NUM_SIZE   = 32,
  parameter int CHUNK_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ready,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  input  logic [2:0]          funct3,
  output logic                valid,
  output logic                equal,
  output logic                greaterThan,
  output logic                lessThan,
  output logic                taken,
  output logic                illegal
);

  localparam int N     = NUM_SIZE / CHUNK_SIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]          f3_q, f3_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                found_q, found_d, sgt_q, sgt_d, slt_q, slt_d;
  logic                eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic                taken_q, taken_d, illegal_q, illegal_d;

  logic [CHUNK_SIZE-1:0] ca, cb;
  logic                  diff, cgt, fin_eq, fin_gt, fin_lt, early_exit;

  // Current chunk; sign bit inverted on the MSB chunk turns two's-complement
  // order into plain unsigned order.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        ca = a_q[k*CHUNK_SIZE +: CHUNK_SIZE];
        cb = b_q[k*CHUNK_SIZE +: CHUNK_SIZE];
      end
    end
    if ((f3_q[2:1] == 2'b10) && (idx_q == IDX_W'(N-1))) begin
      ca[CHUNK_SIZE-1] = ~ca[CHUNK_SIZE-1];
      cb[CHUNK_SIZE-1] = ~cb[CHUNK_SIZE-1];
    end
    diff   = (ca != cb);
    cgt    = (ca > cb);
    fin_gt = found_q ? sgt_q : (diff & cgt);
    fin_lt = found_q ? slt_q : (diff & ~cgt);
    fin_eq = ~found_q & ~diff;
`ifdef COMPARE_EARLY_EXIT_EN
    early_exit = diff;
`else
    early_exit = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    idx_d     = idx_q;
    found_d   = found_q;
    sgt_d     = sgt_q;
    slt_d     = slt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dIn1;
          b_d     = dIn0;
          f3_d    = funct3;
          idx_d   = IDX_W'(N-1);
          found_d = 1'b0;
          sgt_d   = 1'b0;
          slt_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!found_q && diff) begin
          found_d = 1'b1;
          sgt_d   = cgt;
          slt_d   = ~cgt;
        end
        if (early_exit || (idx_q == '0)) begin
          state_d   = DONE;
          eq_d      = fin_eq;
          gt_d      = fin_gt;
          lt_d      = fin_lt;
          illegal_d = (f3_q[2:1] == 2'b01);
          case (f3_q)
            3'b000:          taken_d = fin_eq;
            3'b001:          taken_d = ~fin_eq;
            3'b100, 3'b110:  taken_d = fin_lt;
            3'b101, 3'b111:  taken_d = ~fin_lt;
            default:         taken_d = 1'b0;
          endcase
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      sgt_q     <= 1'b0;
      slt_q     <= 1'b0;
      eq_q      <= 1'b1;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      idx_q     <= idx_d;
      found_q   <= found_d;
      sgt_q     <= sgt_d;
      slt_q     <= slt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign valid       = (state_q == DONE);
  assign equal       = eq_q;
  assign greaterThan = gt_q;
  assign lessThan    = lt_q;
  assign taken       = taken_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire
